// File: rtl/wb_scheduler_pkg.sv
// Shared widths, buffer entry layout and push-count helper for the
// register-bank write-back scheduler.
package wb_pkg;

  localparam int WB_REG_W  = 4;
  localparam int WB_DATA_W = 16;

  typedef struct packed {
    logic [WB_REG_W-1:0]  rg;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // A multiply retires two words, an ALU result one.
  function automatic logic [1:0] push_count(input logic mul_we, input logic alu_we);
    return {mul_we, 1'b0} + {1'b0, alu_we};
  endfunction

endpackage

// File: rtl/wb_scheduler_if.sv
// Producer/bank-side bundle of the write-back scheduler: retire requests,
// decode read probes, the bank write port and the stall/overflow flags.
interface wb_scheduler_if #(
  parameter int REG_W  = wb_pkg::WB_REG_W,
  parameter int DATA_W = wb_pkg::WB_DATA_W
);
  logic              alu_we;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mul_we;
  logic [REG_W-1:0]  mul_reg_h;
  logic [REG_W-1:0]  mul_reg_l;
  logic [DATA_W-1:0] mul_h;
  logic [DATA_W-1:0] mul_l;
  logic              rd_a_en;
  logic              rd_b_en;
  logic [REG_W-1:0]  rd_a;
  logic [REG_W-1:0]  rd_b;
  logic              rf_we;
  logic [REG_W-1:0]  rf_reg;
  logic [DATA_W-1:0] rf_data;
  logic              stall;
  logic              overflow;

  modport master (
    output alu_we, alu_reg, alu_data, mul_we, mul_reg_h, mul_reg_l, mul_h, mul_l,
           rd_a_en, rd_b_en, rd_a, rd_b,
    input  rf_we, rf_reg, rf_data, stall, overflow
  );

  modport slave (
    input  alu_we, alu_reg, alu_data, mul_we, mul_reg_h, mul_reg_l, mul_h, mul_l,
           rd_a_en, rd_b_en, rd_a, rd_b,
    output rf_we, rf_reg, rf_data, stall, overflow
  );
endinterface

// File: rtl/wb_scheduler_fifo.sv
// In-order write buffer: up to three pushes and one pop per edge, with the
// per-entry valid/reg view needed by the read-hazard comparators.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_W  = WB_REG_W,
  parameter int DATA_W = WB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    i_n_push,
  input  logic [2:0][REG_W-1:0]         i_push_reg,
  input  logic [2:0][DATA_W-1:0]        i_push_data,
  output logic [CNT_W-1:0]              o_cnt,
  output logic [REG_W-1:0]              o_head_reg,
  output logic [DATA_W-1:0]             o_head_data,
  output logic [DEPTH-1:0]              o_vld,
  output logic [DEPTH-1:0][REG_W-1:0]   o_regs
);

  localparam int IW = PTR_W + 1;
  typedef logic [IW-1:0] idx_t;

  logic [REG_W-1:0]  r_mem_reg  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic                  w_pop;
  logic [2:0][PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0]      w_wr_next;
  logic [PTR_W-1:0]      w_rd_next;

  // Operand is always below 2*DEPTH, so one conditional subtract is a full modulo.
  function automatic logic [PTR_W-1:0] wrap(input idx_t v);
    idx_t r;
    r = (v >= IW'(DEPTH)) ? v - IW'(DEPTH) : v;
    return r[PTR_W-1:0];
  endfunction

  assign w_pop     = (r_cnt != '0);
  assign w_wr_next = wrap(IW'(r_wr_ptr) + IW'(i_n_push));
  assign w_rd_next = w_pop ? wrap(IW'(r_rd_ptr) + IW'(1)) : r_rd_ptr;

  for (genvar i = 0; i < 3; i++) begin : g_wr_idx
    assign w_wr_idx[i] = wrap(IW'(r_wr_ptr) + IW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_cnt    <= r_cnt + CNT_W'(i_n_push) - CNT_W'(w_pop);
    end
  end

  // When full, the single accepted push lands on the slot being popped this edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < i_n_push) begin
        r_mem_reg[w_wr_idx[i]]  <= i_push_reg[i];
        r_mem_data[w_wr_idx[i]] <= i_push_data[i];
      end
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_view
    logic [PTR_W-1:0] w_off;
    assign w_off     = wrap(IW'(j) + IW'(DEPTH) - IW'(r_rd_ptr));
    assign o_vld[j]  = (IW'(w_off) < IW'(r_cnt));
    assign o_regs[j] = r_mem_reg[j];
  end

  assign o_cnt       = r_cnt;
  assign o_head_reg  = w_pop ? r_mem_reg[r_rd_ptr]  : '0;
  assign o_head_data = w_pop ? r_mem_data[r_rd_ptr] : '0;

endmodule

// File: rtl/wb_scheduler.sv
// Write-back scheduler: orders ALU/multiplier retirements into the write
// buffer, drains one per cycle into the bank, and raises space/hazard stalls.
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_W  = WB_REG_W,
  parameter int DATA_W = WB_DATA_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  wb_scheduler_if.slave   bus
);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic       r_overflow;

  logic [2:0][REG_W-1:0]       w_slot_reg;
  logic [2:0][DATA_W-1:0]      w_slot_data;
  logic [1:0]                  w_n_req;
  logic [1:0]                  w_n_acc;
  logic                        w_drop;
  logic [CNT_W-1:0]            w_cnt;
  logic [CNT_W-1:0]            w_free;
  logic [DEPTH-1:0]            w_vld;
  logic [DEPTH-1:0][REG_W-1:0] w_regs;
  logic [DEPTH-1:0]            w_hit_a;
  logic [DEPTH-1:0]            w_hit_b;
  logic                        w_hazard;
  logic                        w_space_stall;
  logic [REG_W-1:0]            w_head_reg;
  logic [DATA_W-1:0]           w_head_data;

  // Reset asserts immediately; release is retimed to CLOCK_50.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Multiply words are older than a same-cycle ALU result; slots are compacted.
  always_comb begin
    w_slot_reg  = '0;
    w_slot_data = '0;
    if (bus.mul_we) begin
      w_slot_reg[0]  = bus.mul_reg_h;
      w_slot_data[0] = bus.mul_h;
      w_slot_reg[1]  = bus.mul_reg_l;
      w_slot_data[1] = bus.mul_l;
      w_slot_reg[2]  = bus.alu_reg;
      w_slot_data[2] = bus.alu_data;
    end else begin
      w_slot_reg[0]  = bus.alu_reg;
      w_slot_data[0] = bus.alu_data;
    end
  end

  assign w_n_req = push_count(bus.mul_we, bus.alu_we);
  assign w_free  = CNT_W'(DEPTH) - w_cnt + CNT_W'(w_cnt != '0);
  assign w_drop  = (CNT_W'(w_n_req) > w_free);
  assign w_n_acc = w_drop ? w_free[1:0] : w_n_req;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (CLOCK_50),
    .rst_n       (w_rst_n),
    .i_n_push    (w_n_acc),
    .i_push_reg  (w_slot_reg),
    .i_push_data (w_slot_data),
    .o_cnt       (w_cnt),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_vld       (w_vld),
    .o_regs      (w_regs)
  );

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) r_overflow <= 1'b0;
    else          r_overflow <= r_overflow | w_drop;
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_hazard
    assign w_hit_a[j] = w_vld[j] && (w_regs[j] == bus.rd_a);
    assign w_hit_b[j] = w_vld[j] && (w_regs[j] == bus.rd_b);
  end

  assign w_hazard      = (bus.rd_a_en && |w_hit_a) || (bus.rd_b_en && |w_hit_b);
  // Fewer than three free slots cannot absorb a mul+alu retirement.
  assign w_space_stall = (w_cnt > CNT_W'(DEPTH - 3));

  assign bus.rf_we    = (w_cnt != '0);
  assign bus.rf_reg   = w_head_reg;
  assign bus.rf_data  = w_head_data;
  assign bus.stall    = w_space_stall | w_hazard;
  assign bus.overflow = r_overflow;

endmodule
